// File: rtl/axi_lite_rd_arbiter_if.sv
// AXI4-Lite read channel bundle (AR + R) for one requester/completer link.
// The requester uses the master modport and the completer uses the slave modport.
interface axi_lite_rd_arbiter_if #(
  parameter int unsigned AXI_AWIDTH = 4,
  parameter int unsigned AXI_DWIDTH = 32
);
  logic [AXI_AWIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [AXI_DWIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// Two-requester AXI4-Lite read arbiter: round-robin grant and a single outstanding
// transaction. M0 is instruction fetch, M1 is the load path, S is the bus read port.
module axi_lite_rd_arbiter #(
  parameter int unsigned AXI_AWIDTH = 4,
  parameter int unsigned AXI_DWIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   NRST,
  axi_lite_rd_arbiter_if.slave   M0,
  axi_lite_rd_arbiter_if.slave   M1,
  axi_lite_rd_arbiter_if.master  S
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nxt_state;
  logic   r_gnt;
  logic   w_nxt_gnt;
  logic   r_last;
  logic   w_nxt_last;

  logic                  w_s_arvalid;
  logic                  w_s_rready;
  logic                  w_m0_arready;
  logic                  w_m1_arready;
  logic                  w_m0_rvalid;
  logic                  w_m1_rvalid;
  logic [AXI_AWIDTH-1:0] w_araddr;
  logic [AXI_DWIDTH-1:0] w_rdata;

  // State register; last=1 after reset so M0 wins the first tie
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_last  <= w_nxt_last;
    end
  end

  // Next-state and channel routing
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_gnt    = r_gnt;
    w_nxt_last   = r_last;
    w_s_arvalid  = 1'b0;
    w_s_rready   = 1'b0;
    w_m0_arready = 1'b0;
    w_m1_arready = 1'b0;
    w_m0_rvalid  = 1'b0;
    w_m1_rvalid  = 1'b0;

    case (r_state)
      IDLE: begin
        if (M0.ARVALID || M1.ARVALID) begin
          w_nxt_state = ADDR;
          w_nxt_gnt   = (M0.ARVALID && M1.ARVALID) ? ~r_last : M1.ARVALID;
        end
      end
      ADDR: begin
        w_s_arvalid  = r_gnt ? M1.ARVALID : M0.ARVALID;
        w_m0_arready = ~r_gnt & S.ARREADY;
        w_m1_arready =  r_gnt & S.ARREADY;
        if (w_s_arvalid && S.ARREADY) begin
          w_nxt_state = DATA;
        end
      end
      DATA: begin
        w_s_rready  = r_gnt ? M1.RREADY : M0.RREADY;
        w_m0_rvalid = ~r_gnt & S.RVALID;
        w_m1_rvalid =  r_gnt & S.RVALID;
        if (S.RVALID && w_s_rready) begin
          w_nxt_state = IDLE;
          w_nxt_last  = r_gnt;
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  // Address mux follows the grant; read data fans out unqualified, RVALID qualifies it
  assign w_araddr   = r_gnt ? M1.ARADDR : M0.ARADDR;
  assign w_rdata    = S.RDATA;

  assign S.ARADDR   = w_araddr;
  assign S.ARVALID  = w_s_arvalid;
  assign S.RREADY   = w_s_rready;

  assign M0.ARREADY = w_m0_arready;
  assign M0.RVALID  = w_m0_rvalid;
  assign M0.RDATA   = w_rdata;
  assign M0.RRESP   = S.RRESP;

  assign M1.ARREADY = w_m1_arready;
  assign M1.RVALID  = w_m1_rvalid;
  assign M1.RDATA   = w_rdata;
  assign M1.RRESP   = S.RRESP;

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter: reset, single read, round-robin,
// slave wait states, requester backpressure and reset during a data phase.
module tb_axi_lite_rd_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic CLK;
  logic NRST;
  int   checks;
  int   failures;

  axi_lite_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) m0_if ();
  axi_lite_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) m1_if ();
  axi_lite_rd_arbiter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) s_if ();

  axi_lite_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) dut (
    .CLK  (CLK),
    .NRST (NRST),
    .M0   (m0_if.slave),
    .M1   (m1_if.slave),
    .S    (s_if.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [5:0] hs_vec();
    return {s_if.ARVALID, s_if.RREADY, m0_if.ARREADY, m0_if.RVALID,
            m1_if.ARREADY, m1_if.RVALID};
  endfunction

  task automatic clear_inputs();
    m0_if.ARADDR = '0; m0_if.ARVALID = 1'b0; m0_if.RREADY = 1'b0;
    m1_if.ARADDR = '0; m1_if.ARVALID = 1'b0; m1_if.RREADY = 1'b0;
    s_if.ARREADY = 1'b0; s_if.RDATA = '0; s_if.RRESP = 2'b00; s_if.RVALID = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] v;
    clear_inputs();
    NRST = 1'b0;
    repeat (2) tick();
    NRST = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      v = hs_vec();
      checks++;
      if (v !== 6'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: handshake outputs=%b expected=%b", i, v, 6'b0);
      end
      tick();
    end
  endtask

  task automatic test_single_m1();
    logic [5:0] v;
    m1_if.ARADDR = 4'h8; m1_if.ARVALID = 1'b1; m1_if.RREADY = 1'b1;
    s_if.ARREADY = 1'b1;
    #1;
    checks++;
    if (s_if.ARVALID !== 1'b0) begin
      failures++;
      $display("FAIL m1_idle_bubble: S_ARVALID=%b expected=0", s_if.ARVALID);
    end
    tick();
    checks++;
    if (s_if.ARVALID !== 1'b1 || s_if.ARADDR !== 4'h8 || m1_if.ARREADY !== 1'b1 ||
        m0_if.ARREADY !== 1'b0) begin
      failures++;
      $display("FAIL m1_addr: S_ARVALID=%b S_ARADDR=%h M1_ARREADY=%b M0_ARREADY=%b expected 1 8 1 0",
               s_if.ARVALID, s_if.ARADDR, m1_if.ARREADY, m0_if.ARREADY);
    end
    tick();
    m1_if.ARVALID = 1'b0;
    s_if.ARREADY = 1'b0;
    s_if.RVALID = 1'b1; s_if.RDATA = 32'h1234_5678; s_if.RRESP = 2'b00;
    #1;
    checks++;
    if (m1_if.RVALID !== 1'b1 || m1_if.RDATA !== 32'h1234_5678 || m1_if.RRESP !== 2'b00 ||
        m0_if.RVALID !== 1'b0 || s_if.RREADY !== 1'b1) begin
      failures++;
      $display("FAIL m1_data: M1_RVALID=%b M1_RDATA=%h M1_RRESP=%b M0_RVALID=%b S_RREADY=%b expected 1 12345678 00 0 1",
               m1_if.RVALID, m1_if.RDATA, m1_if.RRESP, m0_if.RVALID, s_if.RREADY);
    end
    tick();
    s_if.RVALID = 1'b0;
    m1_if.RREADY = 1'b0;
    #1;
    v = hs_vec();
    checks++;
    if (v !== 6'b0) begin
      failures++;
      $display("FAIL m1_back_idle: handshake outputs=%b expected=%b", v, 6'b0);
    end
  endtask

  task automatic test_round_robin();
    logic       exp_g [4];
    logic [3:0] exp_a;
    logic [31:0] exp_d;
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
    clear_inputs();
    NRST = 1'b0;
    tick();
    NRST = 1'b1;
    m0_if.ARADDR = 4'h4; m1_if.ARADDR = 4'hC;
    m0_if.ARVALID = 1'b1; m1_if.ARVALID = 1'b1;
    m0_if.RREADY = 1'b1; m1_if.RREADY = 1'b1;
    s_if.ARREADY = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_a = exp_g[t] ? 4'hC : 4'h4;
      exp_d = 32'hA5A5_0000 + 32'(t);
      #1;
      checks++;
      if (s_if.ARVALID !== 1'b0 || m0_if.ARREADY !== 1'b0 || m1_if.ARREADY !== 1'b0) begin
        failures++;
        $display("FAIL rr_bubble txn %0d: S_ARVALID=%b M0_ARREADY=%b M1_ARREADY=%b expected 0 0 0",
                 t, s_if.ARVALID, m0_if.ARREADY, m1_if.ARREADY);
      end
      tick();
      checks++;
      if (s_if.ARVALID !== 1'b1 || s_if.ARADDR !== exp_a ||
          m0_if.ARREADY !== ~exp_g[t] || m1_if.ARREADY !== exp_g[t]) begin
        failures++;
        $display("FAIL rr_grant txn %0d: S_ARADDR=%h M0_ARREADY=%b M1_ARREADY=%b expected %h %b %b",
                 t, s_if.ARADDR, m0_if.ARREADY, m1_if.ARREADY, exp_a, ~exp_g[t], exp_g[t]);
      end
      tick();
      s_if.RVALID = 1'b1; s_if.RDATA = exp_d; s_if.RRESP = 2'b10;
      #1;
      checks++;
      if (m0_if.RVALID !== ~exp_g[t] || m1_if.RVALID !== exp_g[t] ||
          (exp_g[t] ? m1_if.RDATA : m0_if.RDATA) !== exp_d ||
          (exp_g[t] ? m1_if.RRESP : m0_if.RRESP) !== 2'b10) begin
        failures++;
        $display("FAIL rr_data txn %0d: M0_RVALID=%b M1_RVALID=%b RDATA=%h RRESP=%b expected %b %b %h 10",
                 t, m0_if.RVALID, m1_if.RVALID, exp_g[t] ? m1_if.RDATA : m0_if.RDATA,
                 exp_g[t] ? m1_if.RRESP : m0_if.RRESP, ~exp_g[t], exp_g[t], exp_d);
      end
      tick();
      s_if.RVALID = 1'b0;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_wait_states();
    int r_hs;
    r_hs = 0;
    m0_if.ARADDR = 4'h6; m0_if.ARVALID = 1'b1; m0_if.RREADY = 1'b1;
    s_if.ARREADY = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s_if.ARVALID !== 1'b1 || s_if.ARADDR !== 4'h6 || m0_if.ARREADY !== 1'b0 ||
          m1_if.ARREADY !== 1'b0) begin
        failures++;
        $display("FAIL ws_addr_hold cycle %0d: S_ARVALID=%b S_ARADDR=%h M0_ARREADY=%b expected 1 6 0",
                 i, s_if.ARVALID, s_if.ARADDR, m0_if.ARREADY);
      end
      tick();
    end
    s_if.ARREADY = 1'b1;
    #1;
    checks++;
    if (m0_if.ARREADY !== 1'b1 || s_if.ARADDR !== 4'h6) begin
      failures++;
      $display("FAIL ws_addr_accept: M0_ARREADY=%b S_ARADDR=%h expected 1 6", m0_if.ARREADY, s_if.ARADDR);
    end
    tick();
    m0_if.ARVALID = 1'b0;
    s_if.ARREADY = 1'b0;
    s_if.RDATA = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      s_if.RVALID = (i == 5);
      #1;
      if (m0_if.RVALID === 1'b1 && m0_if.RREADY === 1'b1) r_hs++;
      checks++;
      if (s_if.RREADY !== 1'b1 || s_if.ARVALID !== 1'b0 || m0_if.RVALID !== (i == 5) ||
          m1_if.RVALID !== 1'b0) begin
        failures++;
        $display("FAIL ws_data_hold cycle %0d: S_RREADY=%b S_ARVALID=%b M0_RVALID=%b M1_RVALID=%b expected 1 0 %b 0",
                 i, s_if.RREADY, s_if.ARVALID, m0_if.RVALID, m1_if.RVALID, (i == 5));
      end
      tick();
    end
    s_if.RVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (m0_if.RVALID === 1'b1 && m0_if.RREADY === 1'b1) r_hs++;
      tick();
    end
    s_if.RVALID = 1'b0;
    checks++;
    if (r_hs !== 1) begin
      failures++;
      $display("FAIL ws_r_handshakes: count=%0d expected=1", r_hs);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [5:0] v;
    m0_if.ARADDR = 4'h2; m0_if.ARVALID = 1'b1; m0_if.RREADY = 1'b0;
    s_if.ARREADY = 1'b1;
    tick();
    tick();
    m0_if.ARVALID = 1'b0;
    s_if.ARREADY = 1'b0;
    s_if.RVALID = 1'b1; s_if.RDATA = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (s_if.RREADY !== 1'b0 || m0_if.RVALID !== 1'b1 || m0_if.RDATA !== 32'h0BAD_F00D) begin
        failures++;
        $display("FAIL bp_stall cycle %0d: S_RREADY=%b M0_RVALID=%b M0_RDATA=%h expected 0 1 0badf00d",
                 i, s_if.RREADY, m0_if.RVALID, m0_if.RDATA);
      end
      tick();
    end
    m0_if.RREADY = 1'b1;
    #1;
    checks++;
    if (s_if.RREADY !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: S_RREADY=%b expected=1", s_if.RREADY);
    end
    tick();
    v = hs_vec();
    checks++;
    if (v !== 6'b0) begin
      failures++;
      $display("FAIL bp_back_idle: handshake outputs=%b expected=%b", v, 6'b0);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_data();
    logic [5:0] v;
    m0_if.ARADDR = 4'h4; m0_if.ARVALID = 1'b1; m0_if.RREADY = 1'b1;
    s_if.ARREADY = 1'b1;
    tick();
    tick();
    m0_if.ARVALID = 1'b0;
    s_if.ARREADY = 1'b0;
    #1;
    checks++;
    if (s_if.RREADY !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_data: S_RREADY=%b expected=1", s_if.RREADY);
    end
    NRST = 1'b0;
    tick();
    NRST = 1'b1;
    s_if.RVALID = 1'b1;
    #1;
    v = hs_vec();
    checks++;
    if (v !== 6'b0) begin
      failures++;
      $display("FAIL rst_abandon: handshake outputs=%b expected=%b", v, 6'b0);
    end
    s_if.RVALID = 1'b0;
    m0_if.ARVALID = 1'b1; m1_if.ARVALID = 1'b1; m1_if.ARADDR = 4'hC;
    s_if.ARREADY = 1'b1;
    tick();
    checks++;
    if (m0_if.ARREADY !== 1'b1 || m1_if.ARREADY !== 1'b0 || s_if.ARADDR !== 4'h4) begin
      failures++;
      $display("FAIL rst_priority: M0_ARREADY=%b M1_ARREADY=%b S_ARADDR=%h expected 1 0 4",
               m0_if.ARREADY, m1_if.ARREADY, s_if.ARADDR);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    NRST = 1'b0;
    clear_inputs();
    test_reset();
    test_single_m1();
    test_round_robin();
    test_wait_states();
    test_backpressure();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Shares one AXI4-Lite read path (AR + R channels) between two read requesters.
- M0 is the instruction-fetch unit; M1 is the load path of the memory stage.
- The S side connects to the single system-bus read port.
- Fair round-robin arbitration, one outstanding transaction total, with no reordering.

Parameters:
AXI_AWIDTH, 4, address width on all ports
AXI_DWIDTH, 32, data width on all ports

Ports:
CLK  input  1  clock
NRST  input  1  reset, synchronous, active-low
M0_ARADDR  input  AXI_AWIDTH  fetch read address
M0_ARVALID  input  1  fetch address valid
M0_ARREADY  output  1  fetch address accepted
M0_RDATA  output  AXI_DWIDTH  read data to fetch
M0_RRESP  output  2  response to fetch
M0_RVALID  output  1  read data valid to fetch
M0_RREADY  input  1  fetch ready for data
M1_ARADDR  input  AXI_AWIDTH  load read address
M1_ARVALID  input  1  load address valid
M1_ARREADY  output  1  load address accepted
M1_RDATA  output  AXI_DWIDTH  read data to load path
M1_RRESP  output  2  response to load path
M1_RVALID  output  1  read data valid to load path
M1_RREADY  input  1  load path ready for data
S_ARADDR  output  AXI_AWIDTH  bus read address
S_ARVALID  output  1  bus address valid
S_ARREADY  input  1  bus address ready
S_RDATA  input  AXI_DWIDTH  bus read data
S_RRESP  input  2  bus response
S_RVALID  input  1  bus data valid
S_RREADY  output  1  bus data ready

Behaviour:
- Registered state: FSM state {IDLE, ADDR, DATA}, grant bit `gnt`, last-served bit `last`.
- Reset (NRST=0 at a CLK edge):
  - state=IDLE, gnt=0, last=1, so M0 has first priority.
  - All VALID/READY outputs are 0 in IDLE and therefore out of reset.
  - Reset mid-transaction abandons the transfer. The bus is not drained.
- IDLE:
  - Only M0 valid: grant M0. Only M1 valid: grant M1.
  - Both valid: grant !last (round-robin).
  - On any grant: latch gnt, go to ADDR next cycle. This is a 1-cycle arbitration bubble.
  - No ARREADY or RVALID is asserted to either master in IDLE.
- ADDR:
  - S_ARADDR = gnt ? M1_ARADDR : M0_ARADDR.
  - S_ARVALID = ARVALID of the granted master.
  - Granted master's ARREADY = S_ARREADY; the other master's ARREADY = 0.
  - On S_ARVALID & S_ARREADY: go to DATA.
  - If the granted ARVALID drops before the handshake (protocol violation), stay in ADDR. No regrant.
- DATA:
  - S_RREADY = RREADY of the granted master.
  - Granted master's RVALID = S_RVALID; the other master's RVALID = 0.
  - On S_RVALID & S_RREADY: last <= gnt, go to IDLE.
- S_ARVALID = 0 outside ADDR. S_RREADY = 0 outside DATA.
- M0_RDATA, M1_RDATA, M0_RRESP and M1_RRESP are driven from S_RDATA/S_RRESP at all times. Qualify them only with RVALID.
- RRESP is passed through unmodified. Error handling belongs to the requester.
- A non-granted master holding ARVALID waits. It is guaranteed service on the next arbitration, so there is no starvation.
- Minimum transaction latency, with a zero-wait slave: AR handshake 1 cycle after the request is seen; R handshake the following cycle or later.
- Back-to-back requests: 1 IDLE cycle always separates transactions.
- All routing outputs are combinational from registered state plus inputs. No combinational path exists from M*_ARVALID to S_ARVALID while in IDLE.

Test Plan:
- Reset then idle: NRST=0 for 2 cycles, no requests → all VALID/READY outputs 0 and S_ARVALID never rises.
- Single M1 read: M1_ARADDR=0x8, slave returns RDATA=0x12345678, RRESP=0 →
  - S_ARADDR=0x8 in ADDR.
  - M1_RVALID with 0x12345678.
  - M0_ARREADY and M0_RVALID stay 0 throughout.
- Simultaneous requests after reset (M0 addr 0x4, M1 addr 0xC, both held) → M0 served first, M1 next. Repeat both → M0 then M1 again.
- Slave wait states: S_ARREADY delayed 3 cycles, S_RVALID delayed 5 cycles → FSM holds ADDR then DATA. Address and grant are stable, and exactly one R handshake is routed to the granted master.
- Master backpressure: granted M0 holds RREADY=0 for 4 cycles while S_RVALID=1 → S_RREADY=0 for those cycles. Completion and return to IDLE happen on the first cycle RREADY=1.
- Reset mid-DATA: assert NRST=0 while in DATA → next cycle state=IDLE, all VALID/READY outputs 0, and M0 has priority on the next simultaneous request.
